// File: rtl/bridge_1xn_if.sv
// Bus bundle between the CPU data port, the 1xN bridge and its slaves.
// The bridge takes the slave modport; the environment (CPU plus slave responses) takes master.
interface bridge_1xn_if #(
    parameter int NUM_SLV = 4,
    parameter int ADDR_WD = 64,
    parameter int DATA_WD = 64
) ();
    localparam int WE_WD = DATA_WD / 8;

    logic                       cpu_data_en;
    logic [WE_WD-1:0]           cpu_data_we;
    logic [ADDR_WD-1:0]         cpu_data_addr;
    logic [DATA_WD-1:0]         cpu_data_wdata;
    logic [DATA_WD-1:0]         cpu_data_rdata;
    logic                       cpu_data_stall;
    logic                       cpu_data_err;
    logic [NUM_SLV-1:0]         slv_en;
    logic [WE_WD-1:0]           slv_we;
    logic [ADDR_WD-1:0]         slv_addr;
    logic [DATA_WD-1:0]         slv_wdata;
    logic [NUM_SLV*DATA_WD-1:0] slv_rdata;
    logic [NUM_SLV-1:0]         slv_ready;

    modport master (
        output cpu_data_en, cpu_data_we, cpu_data_addr, cpu_data_wdata, slv_rdata, slv_ready,
        input  cpu_data_rdata, cpu_data_stall, cpu_data_err, slv_en, slv_we, slv_addr, slv_wdata
    );

    modport slave (
        input  cpu_data_en, cpu_data_we, cpu_data_addr, cpu_data_wdata, slv_rdata, slv_ready,
        output cpu_data_rdata, cpu_data_stall, cpu_data_err, slv_en, slv_we, slv_addr, slv_wdata
    );
endinterface

// File: rtl/bridge_1xn.sv
// Routes one CPU data-SRAM port to NUM_SLV slaves decoded by base/mask, with optional
// ready handshake per slave, a timeout abort and an error response for unmapped addresses.
module bridge_1xn #(
    parameter int                         NUM_SLV  = 4,
    parameter int                         ADDR_WD  = 64,
    parameter int                         DATA_WD  = 64,
    parameter logic [NUM_SLV*ADDR_WD-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_WD-1:0] SLV_MASK = '0,
    parameter logic [NUM_SLV-1:0]         SLV_WAIT = '0,
    parameter int                         TIMEOUT  = 256,
    parameter logic [DATA_WD-1:0]         ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic         clk,
    input  logic         rst_n,
    bridge_1xn_if.slave  bus
);
    localparam int WE_WD  = DATA_WD / 8;
    localparam int CNT_WD = $clog2(TIMEOUT + 1);
    localparam int SEL_WD = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(TIMEOUT);

    typedef enum logic { ST_IDLE, ST_WAIT } state_e;
    typedef enum logic { SRC_SLV, SRC_REG } src_e;

    state_e              state_q, state_d;
    src_e                src_q, src_d;
    logic [SEL_WD-1:0]   sel_q, sel_d;
    logic [DATA_WD-1:0]  rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;
    logic [ADDR_WD-1:0]  req_addr_q, req_addr_d;
    logic [WE_WD-1:0]    req_we_q, req_we_d;
    logic [DATA_WD-1:0]  req_wdata_q, req_wdata_d;

    logic [NUM_SLV-1:0]  hit;
    logic                hit_any;
    logic [SEL_WD-1:0]   hit_idx;
    logic [DATA_WD-1:0]  slv_rdata_arr [NUM_SLV];

    logic [NUM_SLV-1:0]  slv_en_w;
    logic                stall_w;
    logic [ADDR_WD-1:0]  slv_addr_w;
    logic [WE_WD-1:0]    slv_we_w;
    logic [DATA_WD-1:0]  slv_wdata_w;

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_dec
        assign hit[gi] = (bus.cpu_data_addr & SLV_MASK[gi*ADDR_WD +: ADDR_WD])
                         == SLV_BASE[gi*ADDR_WD +: ADDR_WD];
        assign slv_rdata_arr[gi] = bus.slv_rdata[gi*DATA_WD +: DATA_WD];
    end

    // Scan downwards so the lowest-numbered hitting slave is left in hit_idx.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = SEL_WD'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        sel_d       = sel_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        slv_en_w    = '0;
        stall_w     = 1'b0;
        slv_addr_w  = bus.cpu_data_addr;
        slv_we_w    = bus.cpu_data_we;
        slv_wdata_w = bus.cpu_data_wdata;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_data_en) begin
                    if (!hit_any) begin
                        rdata_d = ERR_DATA;
                        src_d   = SRC_REG;
                        err_d   = 1'b1;
                    end else begin
                        slv_en_w[hit_idx] = 1'b1;
                        sel_d             = hit_idx;
                        if (!SLV_WAIT[hit_idx]) begin
                            src_d = SRC_SLV;
                        end else if (bus.slv_ready[hit_idx]) begin
                            rdata_d = slv_rdata_arr[hit_idx];
                            src_d   = SRC_REG;
                        end else begin
                            stall_w     = 1'b1;
                            req_addr_d  = bus.cpu_data_addr;
                            req_we_d    = bus.cpu_data_we;
                            req_wdata_d = bus.cpu_data_wdata;
                            cnt_d       = CNT_WD'(1);
                            state_d     = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // The captured request is replayed so the CPU side may move freely.
                slv_addr_w  = req_addr_q;
                slv_we_w    = req_we_q;
                slv_wdata_w = req_wdata_q;
                if (bus.slv_ready[sel_q]) begin
                    slv_en_w[sel_q] = 1'b1;
                    rdata_d         = slv_rdata_arr[sel_q];
                    src_d           = SRC_REG;
                    state_d         = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    rdata_d = ERR_DATA;
                    src_d   = SRC_REG;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    slv_en_w[sel_q] = 1'b1;
                    stall_w         = 1'b1;
                    cnt_d           = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_SLV;
            sel_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_we_q    <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            sel_q       <= sel_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    assign bus.slv_en         = slv_en_w;
    assign bus.slv_addr       = slv_addr_w;
    assign bus.slv_we         = slv_we_w;
    assign bus.slv_wdata      = slv_wdata_w;
    assign bus.cpu_data_stall = stall_w;
    assign bus.cpu_data_err   = err_q;
    assign bus.cpu_data_rdata = (src_q == SRC_REG) ? rdata_q : slv_rdata_arr[sel_q];
endmodule

// File: tb/tb_bridge_1xn.sv
// Self-checking bench for bridge_1xn: directed vector table, hand sequences for reset
// and back-to-back corners, then random transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_bridge_1xn;
    localparam int NUM_SLV = 4;
    localparam int ADDR_WD = 64;
    localparam int DATA_WD = 64;
    localparam int TIMEOUT = 12;
    localparam logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    // slave0 fast @8xxx, slave1 fast @1xxx, slave2 wait @2xxx, slave3 wait on nibble[29:28]=01
    localparam logic [63:0] B0 = 64'h8000_0000, M0 = 64'hF000_0000;
    localparam logic [63:0] B1 = 64'h1000_0000, M1 = 64'hF000_0000;
    localparam logic [63:0] B2 = 64'h2000_0000, M2 = 64'hF000_0000;
    localparam logic [63:0] B3 = 64'h1000_0000, M3 = 64'h3000_0000;
    localparam logic [NUM_SLV*ADDR_WD-1:0] BASE = {B3, B2, B1, B0};
    localparam logic [NUM_SLV*ADDR_WD-1:0] MASK = {M3, M2, M1, M0};
    localparam logic [NUM_SLV-1:0] WAITS = 4'b1100;

    logic [63:0] base_tab [NUM_SLV];
    logic [63:0] mask_tab [NUM_SLV];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bridge_1xn_if #(.NUM_SLV(NUM_SLV), .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD)) bus ();

    bridge_1xn #(
        .NUM_SLV(NUM_SLV), .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .SLV_WAIT(WAITS),
        .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    function automatic logic [63:0] slave_data(input logic [63:0] addr, input int i);
        return {32'(i + 1) * 32'h0101_0101, addr[31:0]} ^ 64'h0F1E_2D3C_4B5A_6978;
    endfunction

    // Fast slaves register their read data; wait slaves present it combinationally.
    logic [NUM_SLV*DATA_WD-1:0] slv_rdata_tb;
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
        logic [63:0] fast_rd;
        always @(posedge clk) begin
            if (!rst_n) fast_rd <= '0;
            else if (bus.slv_en[gi]) fast_rd <= slave_data(bus.slv_addr, gi);
        end
        assign slv_rdata_tb[gi*DATA_WD +: DATA_WD] = WAITS[gi] ? slave_data(bus.slv_addr, gi) : fast_rd;
    end
    assign bus.slv_rdata = slv_rdata_tb;

    int n_cmp = 0;
    int n_bad = 0;

    logic        pend_v = 1'b0;
    logic        pend_rd_chk;
    logic        pend_err;
    logic [63:0] pend_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_pending(input string tag);
        if (pend_v) begin
            chk($sformatf("%s prev_err", tag), 64'(bus.cpu_data_err), 64'(pend_err));
            if (pend_rd_chk) chk($sformatf("%s prev_rdata", tag), bus.cpu_data_rdata, pend_rd);
            pend_v = 1'b0;
        end
    endtask

    function automatic logic [3:0] ready_with(input int tgt, input logic val);
        logic [3:0] r;
        r = 4'($urandom);
        if (tgt >= 0) r = (r & ~(4'd1 << tgt)) | ({3'd0, val} << tgt);
        return r;
    endfunction

    // Transaction-level reference: which slave answers, how many stall cycles, error or not.
    function automatic void model(input logic [63:0] addr, input int k_low,
                                  output logic [3:0] en, output int stalls, output bit err);
        int t;
        t = -1;
        for (int i = NUM_SLV - 1; i >= 0; i--)
            if ((addr & mask_tab[2'(i)]) == base_tab[2'(i)]) t = i;
        en = '0;
        stalls = 0;
        err = 1'b0;
        if (t < 0) err = 1'b1;
        else begin
            en = 4'd1 << t;
            if (((WAITS >> t) & 4'd1) != 4'd0) begin
                if (k_low <= TIMEOUT) stalls = k_low;
                else begin stalls = TIMEOUT; err = 1'b1; end
            end
        end
    endfunction

    task automatic idle_cycle(input string tag);
        bus.cpu_data_en    = 1'b0;
        bus.cpu_data_addr  = {$urandom, $urandom};
        bus.cpu_data_we    = 8'($urandom);
        bus.cpu_data_wdata = {$urandom, $urandom};
        bus.slv_ready      = 4'($urandom);
        @(negedge clk);
        check_pending(tag);
        chk($sformatf("%s idle_en", tag), 64'(bus.slv_en), 64'd0);
        chk($sformatf("%s idle_stall", tag), 64'(bus.cpu_data_stall), 64'd0);
        chk($sformatf("%s idle_addr", tag), bus.slv_addr, bus.cpu_data_addr);
        @(posedge clk); #1;
        pend_v = 1'b1; pend_err = 1'b0; pend_rd_chk = 1'b0; pend_rd = '0;
    endtask

    task automatic run_txn(input string tag, input logic [63:0] addr, input logic [7:0] we,
                           input logic [63:0] wdata, input int k_low, input bit toggle,
                           input logic [3:0] exp_en, input int exp_stalls, input bit exp_err);
        int tgt;
        bit tmo;
        tgt = -1;
        for (int i = 0; i < NUM_SLV; i++) if (exp_en[2'(i)]) tgt = i;
        tmo = exp_err && (exp_en != 4'd0);
        bus.cpu_data_en    = 1'b1;
        bus.cpu_data_addr  = addr;
        bus.cpu_data_we    = we;
        bus.cpu_data_wdata = wdata;
        bus.slv_ready      = ready_with(tgt, k_low == 0);
        for (int c = 0; c <= exp_stalls; c++) begin
            @(negedge clk);
            if (c == 0) check_pending(tag);
            chk($sformatf("%s en c%0d", tag, c), 64'(bus.slv_en),
                (tmo && c == exp_stalls) ? 64'd0 : 64'(exp_en));
            chk($sformatf("%s stall c%0d", tag, c), 64'(bus.cpu_data_stall), 64'(c < exp_stalls));
            chk($sformatf("%s slv_addr c%0d", tag, c), bus.slv_addr, addr);
            chk($sformatf("%s slv_we c%0d", tag, c), 64'(bus.slv_we), 64'(we));
            chk($sformatf("%s slv_wdata c%0d", tag, c), bus.slv_wdata, wdata);
            @(posedge clk); #1;
            if (toggle) begin
                bus.cpu_data_addr  = {$urandom, $urandom};
                bus.cpu_data_we    = 8'($urandom);
                bus.cpu_data_wdata = {$urandom, $urandom};
            end
            bus.slv_ready = ready_with(tgt, (c + 1) == k_low);
        end
        pend_v      = 1'b1;
        pend_err    = exp_err;
        pend_rd_chk = (we == 8'd0) || exp_err;
        pend_rd     = exp_err ? ERR_DATA : slave_data(addr, tgt);
        bus.cpu_data_en = 1'b0;
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  we;
        int          k_low;
        bit          toggle;
        bit          idle_after;
        logic [3:0]  exp_en;
        int          exp_stalls;
        bit          exp_err;
    } vec_t;

    vec_t tab [10];

    initial begin
        logic [3:0] m_en;
        int m_st;
        bit m_err;
        int nibs [8];

        base_tab = '{B0, B1, B2, B3};
        mask_tab = '{M0, M1, M2, M3};
        nibs = '{8, 1, 2, 5, 9, 13, 0, 7};

        tab[0] = '{64'h8000_0010, 8'h00, 0,           0, 0, 4'b0001, 0,           0};
        tab[1] = '{64'h1000_0020, 8'h00, 0,           0, 1, 4'b0010, 0,           0};
        tab[2] = '{64'h2000_0040, 8'h00, 5,           1, 0, 4'b0100, 5,           0};
        tab[3] = '{64'h0000_0004, 8'hFF, 0,           0, 1, 4'b0000, 0,           1};
        tab[4] = '{64'h5000_0008, 8'h00, 0,           0, 0, 4'b1000, 0,           0};
        tab[5] = '{64'h2000_0100, 8'h00, TIMEOUT + 3, 0, 1, 4'b0100, TIMEOUT,     1};
        tab[6] = '{64'h9000_0000, 8'h0F, 2,           1, 0, 4'b1000, 2,           0};
        tab[7] = '{64'h2000_0200, 8'h00, TIMEOUT,     0, 0, 4'b0100, TIMEOUT,     0};
        tab[8] = '{64'hF000_0000, 8'h00, 0,           0, 1, 4'b0000, 0,           1};
        tab[9] = '{64'hD000_0040, 8'h00, TIMEOUT - 1, 0, 1, 4'b1000, TIMEOUT - 1, 0};

        rst_n = 1'b0;
        bus.cpu_data_en = 1'b0;
        bus.cpu_data_addr = '0;
        bus.cpu_data_we = '0;
        bus.cpu_data_wdata = '0;
        bus.slv_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset slv_en", 64'(bus.slv_en), 64'd0);
        chk("reset stall", 64'(bus.cpu_data_stall), 64'd0);
        chk("reset err", 64'(bus.cpu_data_err), 64'd0);
        chk("reset rdata", bus.cpu_data_rdata, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), tab[4'(i)].addr, tab[4'(i)].we, {$urandom, $urandom},
                    tab[4'(i)].k_low, tab[4'(i)].toggle, tab[4'(i)].exp_en,
                    tab[4'(i)].exp_stalls, tab[4'(i)].exp_err);
            if (tab[4'(i)].idle_after) idle_cycle($sformatf("vec%0d_idle", i));
        end

        // Back-to-back fast reads 0,1,0: each completion observed in the following cycle.
        run_txn("b2b0", 64'h8000_1000, 8'h00, 64'd0, 0, 0, 4'b0001, 0, 0);
        run_txn("b2b1", 64'h1000_2000, 8'h00, 64'd0, 0, 0, 4'b0010, 0, 0);
        run_txn("b2b2", 64'h8000_3000, 8'h00, 64'd0, 0, 0, 4'b0001, 0, 0);
        idle_cycle("b2b_idle");

        // Reset asserted while waiting with cnt=3.
        bus.cpu_data_en = 1'b1;
        bus.cpu_data_addr = 64'h2000_0300;
        bus.cpu_data_we = 8'h00;
        bus.slv_ready = 4'b0000;
        @(negedge clk);
        check_pending("rstwait");
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rstwait stall_before", 64'(bus.cpu_data_stall), 64'd1);
        rst_n = 1'b0;
        bus.cpu_data_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstwait slv_en", 64'(bus.slv_en), 64'd0);
        chk("rstwait stall", 64'(bus.cpu_data_stall), 64'd0);
        chk("rstwait err", 64'(bus.cpu_data_err), 64'd0);
        @(posedge clk); #1;
        run_txn("post_rst", 64'h8000_0040, 8'h00, 64'd0, 0, 0, 4'b0001, 0, 0);
        idle_cycle("post_rst_idle");

        for (int n = 0; n < 150; n++) begin
            logic [63:0] a;
            logic [7:0]  w;
            int k;
            a = {$urandom, 4'(nibs[3'($urandom_range(0, 7))]), 28'($urandom)};
            w = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
            k = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
            model(a, k, m_en, m_st, m_err);
            run_txn($sformatf("rnd%0d", n), a, w, {$urandom, $urandom}, k,
                    $urandom_range(0, 1) != 0, m_en, m_st, m_err);
            if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rnd%0d_idle", n));
        end
        idle_cycle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
